// File: rtl/csr_timer_pkg.sv
// Shared definitions for the CSR timer bank: register offsets within a
// channel window, TCFG field positions and the pending-index encoder.
package csr_timer_pkg;

   // Register offset inside one channel's 4-entry CSR window
   typedef enum logic [1:0] {
      REG_TCFG  = 2'd0,
      REG_TVAL  = 2'd1,
      REG_TICLR = 2'd2,
      REG_TPRE  = 2'd3
   } csr_reg_e;

   localparam int CH_STRIDE     = 4;
   localparam int MAX_CH        = 8;

   // TCFG field positions
   localparam int TCFG_EN_BIT   = 0;
   localparam int TCFG_PER_BIT  = 1;
   localparam int TCFG_INIT_LSB = 2;

   // Masked CSR write: bits with mask=1 take the new value, others keep old
   function automatic logic [31:0] csr_merge(input logic [31:0] mask,
                                             input logic [31:0] value,
                                             input logic [31:0] old);
      return (mask & value) | (~mask & old);
   endfunction

   // Index of the lowest set bit; 0 when nothing is set
   function automatic logic [2:0] pend_index(input logic [MAX_CH-1:0] pend);
      logic [2:0] idx;
      idx = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (pend[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/csr_timer_ch.sv
// One timer channel: TCFG/TPRE register fields, prescaler, down-counter and
// the pending flag. CSR address decode is done by the parent.
module csr_timer_ch
   import csr_timer_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PRE_W = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_cfg_we,
   input  logic        i_pre_we,
   input  logic        i_clr,
   input  logic [31:0] i_wmask,
   input  logic [31:0] i_wvalue,
   output logic [31:0] o_cfg,
   output logic [31:0] o_tval,
   output logic [31:0] o_tpre,
   output logic        o_pend
);

   localparam int INIT_W = CNT_W - TCFG_INIT_LSB;

   logic              r_en;
   logic              r_periodic;
   logic              r_pend;
   logic [INIT_W-1:0] r_initval;
   logic [PRE_W-1:0]  r_pre;
   logic [PRE_W-1:0]  r_pcnt;
   logic [CNT_W-1:0]  r_cnt;

   logic [31:0]       w_cfg_new;
   logic [31:0]       w_pre_new;
   logic [INIT_W-1:0] w_initval_new;
   logic              w_en_new;
   logic              w_load;
   logic              w_run;
   logic              w_tick;
   logic              w_stopped;
   logic              w_expire;
   logic              w_unused_bits;

   assign o_cfg  = (32'(r_initval)  << TCFG_INIT_LSB)
                 | (32'(r_periodic) << TCFG_PER_BIT)
                 | (32'(r_en)       << TCFG_EN_BIT);
   assign o_tval = 32'(r_cnt);
   assign o_tpre = 32'(r_pre);
   assign o_pend = r_pend;

   // Bits above the field widths are simply dropped after the merge
   assign w_cfg_new     = csr_merge(i_wmask, i_wvalue, o_cfg);
   assign w_pre_new     = csr_merge(i_wmask, i_wvalue, o_tpre);
   assign w_en_new      = w_cfg_new[TCFG_EN_BIT];
   assign w_initval_new = w_cfg_new[TCFG_INIT_LSB +: INIT_W];
   assign w_unused_bits = ^{w_cfg_new, w_pre_new};

   // A TCFG write that leaves the channel enabled restarts it; this beats
   // any tick in the same cycle.
   assign w_load    = i_cfg_we & w_en_new;
   assign w_run     = r_en & ~i_stall;
   assign w_tick    = w_run & (r_pcnt == r_pre);
   assign w_stopped = (r_cnt == '1);
   assign w_expire  = w_tick & ~w_load & (r_cnt == '0);

   // TCFG fields
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_en       <= 1'b0;
         r_periodic <= 1'b0;
         r_initval  <= '0;
      end else if (i_cfg_we) begin
         r_en       <= w_en_new;
         r_periodic <= w_cfg_new[TCFG_PER_BIT];
         r_initval  <= w_initval_new;
      end
   end

   // TPRE register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pre <= '0;
      end else if (i_pre_we) begin
         r_pre <= w_pre_new[PRE_W-1:0];
      end
   end

   // Prescale count: restart on load, wrap to 0 on each tick, hold when frozen.
   // If TPRE is lowered below the current count it runs the long way round.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pcnt <= '0;
      end else if (w_load) begin
         r_pcnt <= '0;
      end else if (w_run) begin
         r_pcnt <= w_tick ? '0 : r_pcnt + PRE_W'(1);
      end
   end

   // Down-counter: all-ones means a one-shot that has already fired
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '1;
      end else if (w_load) begin
         r_cnt <= {w_initval_new, 2'b00};
      end else if (w_tick && !w_stopped) begin
         if (r_cnt != '0)     r_cnt <= r_cnt - CNT_W'(1);
         else if (r_periodic) r_cnt <= {r_initval, 2'b00};
         else                 r_cnt <= '1;
      end
   end

   // Pending flag: an expiry in the same cycle as a clear keeps it set
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend <= 1'b0;
      end else if (w_expire) begin
         r_pend <= 1'b1;
      end else if (i_clr) begin
         r_pend <= 1'b0;
      end
   end

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of NUM_CH CSR-mapped down-counting timers with a shared read mux,
// write decode and lowest-index interrupt encoding.
module csr_timer_bank
   import csr_timer_pkg::*;
#(
   parameter int          NUM_CH = 4,
   parameter int          CNT_W  = 32,
   parameter int          PRE_W  = 8,
   parameter logic [13:0] BASE   = 14'h0060
) (
   input  logic                                            clk,
   input  logic                                            resetn,
   input  logic                                            csr_re,
   input  logic [13:0]                                     csr_rnum,
   output logic [31:0]                                     csr_rvalue,
   input  logic                                            csr_we,
   input  logic [13:0]                                     csr_wnum,
   input  logic [31:0]                                     csr_wmask,
   input  logic [31:0]                                     csr_wvalue,
   input  logic                                            timer_stall,
   output logic [NUM_CH-1:0]                               irq_pending,
   output logic                                            has_timer_int,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  timer_int_id
);

   localparam int          ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [13:0] SPAN = 14'(CH_STRIDE * NUM_CH);

   logic [13:0]       w_roff;
   logic [13:0]       w_woff;
   logic              w_rmapped;
   logic              w_wmapped;
   logic [2:0]        w_rch;
   logic [2:0]        w_wch;
   csr_reg_e          w_rreg;
   csr_reg_e          w_wreg;
   logic [31:0]       w_rdata;
   logic [NUM_CH-1:0] w_wsel;
   logic [NUM_CH-1:0] w_cfg_we;
   logic [NUM_CH-1:0] w_pre_we;
   logic [NUM_CH-1:0] w_clr;
   logic [NUM_CH-1:0] w_pend;
   logic [31:0]       w_cfg_rd  [NUM_CH];
   logic [31:0]       w_tval_rd [NUM_CH];
   logic [31:0]       w_tpre_rd [NUM_CH];
   logic [MAX_CH-1:0] w_pend_ext;
   logic [2:0]        w_id;
   logic              w_unused_top;

   // Address decode: offset from BASE splits into channel and register
   assign w_roff    = csr_rnum - BASE;
   assign w_woff    = csr_wnum - BASE;
   assign w_rmapped = (csr_rnum >= BASE) && (w_roff < SPAN);
   assign w_wmapped = (csr_wnum >= BASE) && (w_woff < SPAN);
   assign w_rch     = w_roff[4:2];
   assign w_wch     = w_woff[4:2];
   assign w_rreg    = csr_reg_e'(w_roff[1:0]);
   assign w_wreg    = csr_reg_e'(w_woff[1:0]);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wsel[g]   = csr_we && w_wmapped && (w_wch == 3'(g));
      assign w_cfg_we[g] = w_wsel[g] && (w_wreg == REG_TCFG);
      assign w_pre_we[g] = w_wsel[g] && (w_wreg == REG_TPRE);
      assign w_clr[g]    = w_wsel[g] && (w_wreg == REG_TICLR)
                         && csr_wmask[0] && csr_wvalue[0];

      csr_timer_ch #(
         .CNT_W (CNT_W),
         .PRE_W (PRE_W)
      ) u_ch (
         .i_clk    (clk),
         .i_rst_n  (resetn),
         .i_stall  (timer_stall),
         .i_cfg_we (w_cfg_we[g]),
         .i_pre_we (w_pre_we[g]),
         .i_clr    (w_clr[g]),
         .i_wmask  (csr_wmask),
         .i_wvalue (csr_wvalue),
         .o_cfg    (w_cfg_rd[g]),
         .o_tval   (w_tval_rd[g]),
         .o_tpre   (w_tpre_rd[g]),
         .o_pend   (w_pend[g])
      );
   end

   // Read mux: returns register state before any same-cycle write; TICLR
   // and unmapped numbers read 0
   always_comb begin
      w_rdata = '0;
      if (csr_re && w_rmapped) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_rch == 3'(c)) begin
               case (w_rreg)
                  REG_TCFG: w_rdata = w_cfg_rd[c];
                  REG_TVAL: w_rdata = w_tval_rd[c];
                  REG_TPRE: w_rdata = w_tpre_rd[c];
                  default:  w_rdata = '0;
               endcase
            end
         end
      end
   end

   assign csr_rvalue    = w_rdata;
   assign irq_pending   = w_pend;
   assign has_timer_int = |w_pend;
   assign w_pend_ext    = MAX_CH'(w_pend);
   assign w_id          = pend_index(w_pend_ext);
   assign timer_int_id  = w_id[ID_W-1:0];
   assign w_unused_top  = ^{w_roff, w_woff, w_id};

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: a register-access vector table followed
// by hand-timed sequences for counting, reload, pending, stall and reset.
module tb_csr_timer_bank;

   logic        clk = 1'b0;
   logic        resetn;
   logic        csr_re, csr_we, timer_stall;
   logic [13:0] csr_rnum, csr_wnum;
   logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
   logic [3:0]  irq_pending;
   logic        has_timer_int;
   logic [1:0]  timer_int_id;

   logic        b_re, b_we;
   logic [13:0] b_rnum, b_wnum;
   logic [31:0] b_wmask, b_wvalue, b_rvalue;
   logic [0:0]  b_irq;
   logic        b_has;
   logic [0:0]  b_id;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          wr;
      bit          re;
      logic [13:0] num;
      logic [31:0] mask;
      logic [31:0] val;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[20];

   always #5 clk = ~clk;

   csr_timer_bank #(
      .NUM_CH (4), .CNT_W (32), .PRE_W (8), .BASE (14'h0060)
   ) u_dut (
      .clk           (clk),
      .resetn        (resetn),
      .csr_re        (csr_re),
      .csr_rnum      (csr_rnum),
      .csr_rvalue    (csr_rvalue),
      .csr_we        (csr_we),
      .csr_wnum      (csr_wnum),
      .csr_wmask     (csr_wmask),
      .csr_wvalue    (csr_wvalue),
      .timer_stall   (timer_stall),
      .irq_pending   (irq_pending),
      .has_timer_int (has_timer_int),
      .timer_int_id  (timer_int_id)
   );

   csr_timer_bank #(
      .NUM_CH (1), .CNT_W (16), .PRE_W (8), .BASE (14'h0060)
   ) u_dut1 (
      .clk           (clk),
      .resetn        (resetn),
      .csr_re        (b_re),
      .csr_rnum      (b_rnum),
      .csr_rvalue    (b_rvalue),
      .csr_we        (b_we),
      .csr_wnum      (b_wnum),
      .csr_wmask     (b_wmask),
      .csr_wvalue    (b_wvalue),
      .timer_stall   (timer_stall),
      .irq_pending   (b_irq),
      .has_timer_int (b_has),
      .timer_int_id  (b_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one write for a full cycle; returns on the negedge after the write edge
   task automatic wr(input bit sel, input logic [13:0] num, input logic [31:0] mask,
                     input logic [31:0] val);
      if (sel) begin
         b_we = 1'b1; b_wnum = num; b_wmask = mask; b_wvalue = val;
      end else begin
         csr_we = 1'b1; csr_wnum = num; csr_wmask = mask; csr_wvalue = val;
      end
      @(negedge clk);
      csr_we = 1'b0;
      b_we   = 1'b0;
   endtask

   task automatic rdchk(input bit sel, input logic [13:0] num, input logic [31:0] exp,
                        input string name);
      if (sel) begin
         b_re = 1'b1; b_rnum = num;
      end else begin
         csr_re = 1'b1; csr_rnum = num;
      end
      #1;
      chk(name, sel ? b_rvalue : csr_rvalue, exp);
      csr_re = 1'b0;
      b_re   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0; timer_stall = 1'b0;
      csr_re = 1'b0; csr_we = 1'b0; csr_rnum = '0; csr_wnum = '0;
      csr_wmask = '0; csr_wvalue = '0;
      b_re = 1'b0; b_we = 1'b0; b_rnum = '0; b_wnum = '0;
      b_wmask = '0; b_wvalue = '0;

      //            wr  re  num       mask          value         expected
      vecs[0]  = '{1'b0, 1'b1, 14'h060, 32'h0,        32'h0,        32'h0000_0000};
      vecs[1]  = '{1'b0, 1'b1, 14'h061, 32'h0,        32'h0,        32'hFFFF_FFFF};
      vecs[2]  = '{1'b0, 1'b1, 14'h063, 32'h0,        32'h0,        32'h0000_0000};
      vecs[3]  = '{1'b0, 1'b1, 14'h05F, 32'h0,        32'h0,        32'h0000_0000};
      vecs[4]  = '{1'b1, 1'b0, 14'h06B, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0};
      vecs[5]  = '{1'b0, 1'b1, 14'h06B, 32'h0,        32'h0,        32'h0000_0034};
      vecs[6]  = '{1'b1, 1'b0, 14'h06B, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 14'h06B, 32'h0,        32'h0,        32'h0000_003F};
      vecs[8]  = '{1'b0, 1'b1, 14'h06A, 32'h0,        32'h0,        32'h0000_0000};
      vecs[9]  = '{1'b1, 1'b0, 14'h06C, 32'hFFFF_FFFF, 32'h0000_0102, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 14'h06C, 32'h0,        32'h0,        32'h0000_0102};
      vecs[11] = '{1'b0, 1'b1, 14'h06D, 32'h0,        32'h0,        32'hFFFF_FFFF};
      vecs[12] = '{1'b0, 1'b0, 14'h06C, 32'h0,        32'h0,        32'h0000_0000};
      vecs[13] = '{1'b0, 1'b1, 14'h070, 32'h0,        32'h0,        32'h0000_0000};
      vecs[14] = '{1'b1, 1'b0, 14'h06C, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0};
      vecs[15] = '{1'b0, 1'b1, 14'h06C, 32'h0,        32'h0,        32'h0000_0000};
      vecs[16] = '{1'b1, 1'b0, 14'h06D, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0};
      vecs[17] = '{1'b0, 1'b1, 14'h06D, 32'h0,        32'h0,        32'hFFFF_FFFF};
      vecs[18] = '{1'b1, 1'b0, 14'h06B, 32'h0000_00FF, 32'h0000_0000, 32'h0};
      vecs[19] = '{1'b0, 1'b1, 14'h06B, 32'h0,        32'h0,        32'h0000_0000};

      step(3);
      resetn = 1'b1;

      chk("reset_irq", 32'(irq_pending), 32'h0);
      chk("reset_has", 32'(has_timer_int), 32'h0);

      // Register access table
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) begin
            wr(1'b0, vecs[i].num, vecs[i].mask, vecs[i].val);
         end else begin
            csr_re   = vecs[i].re;
            csr_rnum = vecs[i].num;
            #1;
            chk($sformatf("vec%0d", i), csr_rvalue, vecs[i].exp);
            csr_re = 1'b0;
            @(negedge clk);
         end
      end

      // One-shot on ch0: init 5 -> 20, fires on the 21st tick then stops
      wr(1'b0, 14'h060, 32'hFFFF_FFFF, 32'h0000_0015);
      rdchk(1'b0, 14'h061, 32'd20, "os_load");
      step(10);
      rdchk(1'b0, 14'h061, 32'd10, "os_mid");
      step(10);
      rdchk(1'b0, 14'h061, 32'd0, "os_zero");
      chk("os_nopend", 32'(irq_pending), 32'h0);
      step(1);
      chk("os_pend", 32'(irq_pending), 32'h1);
      chk("os_has", 32'(has_timer_int), 32'h1);
      rdchk(1'b0, 14'h061, 32'hFFFF_FFFF, "os_stop");
      step(5);
      rdchk(1'b0, 14'h061, 32'hFFFF_FFFF, "os_stays");
      wr(1'b0, 14'h062, 32'h1, 32'h1);
      chk("os_clr", 32'(irq_pending), 32'h0);

      // Periodic on ch1 with TPRE=3: one decrement per 4 cycles, reload to 8
      wr(1'b0, 14'h067, 32'hFFFF_FFFF, 32'd3);
      wr(1'b0, 14'h064, 32'hFFFF_FFFF, 32'h0000_000B);
      rdchk(1'b0, 14'h065, 32'd8, "per_load");
      step(3);
      rdchk(1'b0, 14'h065, 32'd8, "per_hold3");
      step(1);
      rdchk(1'b0, 14'h065, 32'd7, "per_dec4");
      step(28);
      rdchk(1'b0, 14'h065, 32'd0, "per_zero");
      chk("per_nopend", 32'(irq_pending), 32'h0);
      step(4);
      chk("per_pend1", 32'(irq_pending), 32'h2);
      rdchk(1'b0, 14'h065, 32'd8, "per_reload1");
      wr(1'b0, 14'h066, 32'h1, 32'h1);
      chk("per_clr", 32'(irq_pending), 32'h0);
      step(34);
      rdchk(1'b0, 14'h065, 32'd0, "per_zero2");
      chk("per_nopend2", 32'(irq_pending), 32'h0);
      step(1);
      chk("per_pend2", 32'(irq_pending), 32'h2);
      rdchk(1'b0, 14'h065, 32'd8, "per_reload2");
      wr(1'b0, 14'h064, 32'hFFFF_FFFF, 32'h0);
      wr(1'b0, 14'h066, 32'h1, 32'h1);
      chk("per_off", 32'(irq_pending), 32'h0);

      // Priority encode and clear-vs-expiry on ch2/ch3
      wr(1'b0, 14'h068, 32'hFFFF_FFFF, 32'h0000_0001);
      wr(1'b0, 14'h06C, 32'hFFFF_FFFF, 32'h0000_0007);
      chk("pri_p2", 32'(irq_pending), 32'h4);
      step(5);
      chk("pri_both", 32'(irq_pending), 32'hC);
      chk("pri_id2", 32'(timer_int_id), 32'd2);
      wr(1'b0, 14'h06A, 32'h1, 32'h1);
      chk("pri_p3", 32'(irq_pending), 32'h8);
      chk("pri_id3", 32'(timer_int_id), 32'd3);
      step(3);
      rdchk(1'b0, 14'h06D, 32'd0, "pri_ch3_zero");
      wr(1'b0, 14'h06E, 32'h1, 32'h1);
      chk("set_wins", 32'(irq_pending), 32'h8);
      rdchk(1'b0, 14'h06D, 32'd4, "set_reload");
      wr(1'b0, 14'h06E, 32'h1, 32'h1);
      chk("clr_ch3", 32'(irq_pending), 32'h0);
      chk("clr_id", 32'(timer_int_id), 32'd0);
      chk("clr_has", 32'(has_timer_int), 32'h0);
      wr(1'b0, 14'h06C, 32'hFFFF_FFFF, 32'h0);

      // Debug stall freezes the counter for 10 cycles
      wr(1'b0, 14'h060, 32'hFFFF_FFFF, 32'h0000_0191);
      step(5);
      rdchk(1'b0, 14'h061, 32'd395, "stl_before");
      timer_stall = 1'b1;
      step(10);
      rdchk(1'b0, 14'h061, 32'd395, "stl_frozen");
      timer_stall = 1'b0;
      step(3);
      rdchk(1'b0, 14'h061, 32'd392, "stl_resume");

      // Asynchronous reset mid-count with a pending bit set
      wr(1'b0, 14'h068, 32'hFFFF_FFFF, 32'h0000_0001);
      step(1);
      chk("rst_pre_pend", 32'(irq_pending), 32'h4);
      #1;
      resetn = 1'b0;
      #1;
      chk("rst_irq", 32'(irq_pending), 32'h0);
      chk("rst_has", 32'(has_timer_int), 32'h0);
      chk("rst_id", 32'(timer_int_id), 32'h0);
      rdchk(1'b0, 14'h061, 32'hFFFF_FFFF, "rst_tval");
      rdchk(1'b0, 14'h060, 32'h0, "rst_tcfg");
      step(2);
      resetn = 1'b1;
      wr(1'b0, 14'h060, 32'hFFFF_FFFF, 32'h0000_0015);
      rdchk(1'b0, 14'h061, 32'd20, "rst_first_edge");

      // Single-channel, 16-bit build
      rdchk(1'b1, 14'h061, 32'h0000_FFFF, "n1_reset_tval");
      wr(1'b1, 14'h060, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      rdchk(1'b1, 14'h060, 32'h0000_FFFE, "n1_tcfg_upper");
      rdchk(1'b1, 14'h064, 32'h0, "n1_unmapped");
      wr(1'b1, 14'h060, 32'hFFFF_FFFF, 32'h0000_0009);
      rdchk(1'b1, 14'h061, 32'd8, "n1_load");
      step(8);
      rdchk(1'b1, 14'h061, 32'd0, "n1_zero");
      chk("n1_nopend", 32'(b_irq), 32'h0);
      step(1);
      chk("n1_pend", 32'(b_irq), 32'h1);
      chk("n1_has", 32'(b_has), 32'h1);
      chk("n1_id", 32'(b_id), 32'h0);
      rdchk(1'b1, 14'h061, 32'h0000_FFFF, "n1_stop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
